// File: rtl/mdu_ctrl.sv
// Multiply/divide unit for the E stage: owns HI/LO, sequences mult/div with a fixed busy count, executes mthi/mtlo.
// Latency: mult/div results commit MULT_CYCLES/DIV_CYCLES edges after issue; mthi/mtlo write on the issue edge.
// Backpressure: stall_req freezes D-stage HI/LO users while busy or while a long op issues; ops arriving while busy are ignored.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mf_sel,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_out
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_sh_hi;
    logic [31:0] r_sh_lo;
    logic        r_dz;

    // Products: sign-extend to 64 bits so a plain 64-bit multiply yields the signed result.
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    assign w_prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide via magnitudes: quotient truncates toward zero, remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally as lo=0x80000000, hi=0.
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_mag_safe;
    logic [31:0] w_rt_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q_s;
    logic [31:0] w_r_s;
    logic [31:0] w_q_u;
    logic [31:0] w_r_u;
    logic        w_div_zero;
    assign w_div_zero   = (rt_val == 32'd0);
    assign w_a_mag      = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
    assign w_b_mag      = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
    assign w_b_mag_safe = w_div_zero ? 32'd1 : w_b_mag;
    assign w_rt_safe    = w_div_zero ? 32'd1 : rt_val;
    assign w_q_mag      = w_a_mag / w_b_mag_safe;
    assign w_r_mag      = w_a_mag % w_b_mag_safe;
    assign w_q_s        = (rs_val[31] ^ rt_val[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_r_s        = rs_val[31] ? (~w_r_mag + 32'd1) : w_r_mag;
    assign w_q_u        = rs_val / w_rt_safe;
    assign w_r_u        = rs_val % w_rt_safe;

    logic w_long_op;
    assign w_long_op = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                       (md_op == OP_DIV)  || (md_op == OP_DIVU);

    // Sequencer: issue captures the result into shadow regs, RUN counts down and commits on the last edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_sh_hi <= 32'd0;
            r_sh_lo <= 32'd0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (md_op)
                            OP_MULT: begin
                                {r_sh_hi, r_sh_lo} <= w_prod_s;
                                r_dz    <= 1'b0;
                                r_cnt   <= LP_MULT_CNT;
                                r_state <= S_RUN;
                            end
                            OP_MULTU: begin
                                {r_sh_hi, r_sh_lo} <= w_prod_u;
                                r_dz    <= 1'b0;
                                r_cnt   <= LP_MULT_CNT;
                                r_state <= S_RUN;
                            end
                            OP_DIV: begin
                                r_sh_lo <= w_q_s;
                                r_sh_hi <= w_r_s;
                                r_dz    <= w_div_zero;
                                r_cnt   <= LP_DIV_CNT;
                                r_state <= S_RUN;
                            end
                            OP_DIVU: begin
                                r_sh_lo <= w_q_u;
                                r_sh_hi <= w_r_u;
                                r_dz    <= w_div_zero;
                                r_cnt   <= LP_DIV_CNT;
                                r_state <= S_RUN;
                            end
                            OP_MTHI: r_hi <= rs_val;
                            OP_MTLO: r_lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (r_cnt == 4'd1) begin
                        if (!r_dz) begin
                            r_hi <= r_sh_hi;
                            r_lo <= r_sh_lo;
                        end
                        r_cnt   <= 4'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_cnt   <= 4'd0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state == S_RUN);
    assign stall_req = d_md_use & (busy | (start & w_long_op));
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign mf_out    = mf_sel ? r_hi : r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed vectors, commit results scored from a queue by a separate monitor.
// Latency: monitor checks each busy run length and HI/LO in the cycle busy falls.
// Backpressure: inline checks cover stall_req and mf_out cycle by cycle.
module tb_mdu_ctrl;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mf_sel;
    logic        d_md_use;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_out;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .mf_sel    (mf_sel),
        .d_md_use  (d_md_use),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo),
        .mf_out    (mf_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] v);
        start = 1'b1; md_op = op; rs_val = v;
        tick();
        start = 1'b0; md_op = OP_NONE;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        e.name = name; e.cyc = n; e.hi = ehi; e.lo = elo;
        q.push_back(e);
        start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        tick();
        start = 1'b0; md_op = OP_NONE;
        repeat (n + 1) tick();
    endtask

    // Monitor: a falling busy marks a completed (or reset-aborted) op; score it against the queue head.
    initial begin
        int   run_len;
        bit   prev_busy;
        exp_t e;
        run_len   = 0;
        prev_busy = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                run_len++;
            end else if (prev_busy) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: busy fell with no expected entry at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk({e.name, "_busy_len"}, 32'(run_len), 32'(e.cyc));
                    chk({e.name, "_hi"}, hi, e.hi);
                    chk({e.name, "_lo"}, lo, e.lo);
                end
                run_len = 0;
            end
            prev_busy = (busy === 1'b1);
        end
    end

    // Issuing while an op is in flight is a hazard-unit violation.
    always @(negedge clk) begin
        if (!reset && busy && start) begin
            n_fail++;
            $display("FAIL start_while_busy: start=1 while busy=1 at %0t", $time);
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; md_op = OP_NONE; rs_val = '0; rt_val = '0;
        mf_sel = 1'b0; d_md_use = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        tick();
        reset = 1'b0;

        // Reset mid-op: MULT 3*4 issued in t, reset in t+2, nothing commits at t+6.
        begin
            exp_t e;
            e.name = "rst_mid"; e.cyc = 2; e.hi = 32'd0; e.lo = 32'd0;
            q.push_back(e);
        end
        start = 1'b1; md_op = OP_MULT; rs_val = 32'd3; rt_val = 32'd4;
        tick();                                   // t+1
        start = 1'b0; md_op = OP_NONE;
        tick();                                   // t+2
        reset = 1'b1;
        tick();                                   // t+3
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        repeat (3) tick();                        // t+6
        @(negedge clk);
        chk("rst_mid_t6_hi", hi, 32'd0);
        chk("rst_mid_t6_lo", lo, 32'd0);
        tick();
        @(negedge clk);
        chk("rst_mid_t7_lo", lo, 32'd0);
        tick();

        // MULT -2*3 with a D-stage HI/LO user: stall on issue and through all busy cycles.
        begin
            exp_t e;
            e.name = "mult_neg"; e.cyc = 5; e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FFFA;
            q.push_back(e);
        end
        d_md_use = 1'b1;
        start = 1'b1; md_op = OP_MULT; rs_val = 32'hFFFF_FFFE; rt_val = 32'd3;
        @(negedge clk);
        chk("stall_issue", {31'd0, stall_req}, 32'd1);
        tick();
        start = 1'b0; md_op = OP_NONE;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall_busy_%0d", k), {31'd0, stall_req}, 32'd1);
            tick();
        end
        @(negedge clk);
        chk("stall_after", {31'd0, stall_req}, 32'd0);
        d_md_use = 1'b0;
        tick();

        // MULTU same operands, no D-stage user: stall stays low throughout.
        begin
            exp_t e;
            e.name = "multu"; e.cyc = 5; e.hi = 32'h0000_0002; e.lo = 32'hFFFF_FFFA;
            q.push_back(e);
        end
        start = 1'b1; md_op = OP_MULTU; rs_val = 32'hFFFF_FFFE; rt_val = 32'd3;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("nostall_%0d", k), {31'd0, stall_req}, 32'd0);
            tick();
            start = 1'b0; md_op = OP_NONE;
        end

        run_op("div_neg", OP_DIV,  32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",    OP_DIVU, 32'd7,         32'd2, 10, 32'd1,         32'd3);

        // MTHI/MTLO preload: single-edge write, never stalls, never busy.
        d_md_use = 1'b1;
        start = 1'b1; md_op = OP_MTHI; rs_val = 32'h11;
        @(negedge clk);
        chk("mthi_stall", {31'd0, stall_req}, 32'd0);
        tick();
        start = 1'b0; md_op = OP_NONE;
        @(negedge clk);
        chk("mthi_hi", hi, 32'h11);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        start = 1'b1; md_op = OP_MTLO; rs_val = 32'h22;
        #1;
        chk("mtlo_stall", {31'd0, stall_req}, 32'd0);
        tick();
        start = 1'b0; md_op = OP_NONE;
        @(negedge clk);
        chk("mtlo_lo", lo, 32'h22);
        d_md_use = 1'b0;
        tick();

        run_op("div_zero", OP_DIV, 32'd5, 32'd0, 10, 32'h11, 32'h22);
        run_op("div_ovf",  OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

        // Reserved opcode with start: no state change.
        start = 1'b1; md_op = OP_RSVD; rs_val = 32'hDEAD_BEEF;
        tick();
        start = 1'b0; md_op = OP_NONE;
        @(negedge clk);
        chk("rsvd_busy", {31'd0, busy}, 32'd0);
        chk("rsvd_hi", hi, 32'd0);
        chk("rsvd_lo", lo, 32'h8000_0000);
        tick();

        // mflo during RUN shows committed LO only, switching on the commit edge.
        mt(OP_MTLO, 32'h5);
        begin
            exp_t e;
            e.name = "mult_mf"; e.cyc = 5; e.hi = 32'd0; e.lo = 32'd6;
            q.push_back(e);
        end
        mf_sel = 1'b0;
        start = 1'b1; md_op = OP_MULT; rs_val = 32'd2; rt_val = 32'd3;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("mflo_run_%0d", k), mf_out, 32'h5);
            tick();
            start = 1'b0; md_op = OP_NONE;
        end
        @(negedge clk);
        chk("mflo_commit", mf_out, 32'h6);
        mf_sel = 1'b1;
        #1;
        chk("mfhi_commit", mf_out, 32'h0);
        tick();
        tick();

        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected results never observed", q.size());
        end
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multiply/divide unit with its sequencing controller for the five-stage MIPS pipeline. It sits in the E stage beside the ALU and owns the HI/LO registers. It runs a fixed-latency busy counter for mult/multu/div/divu and executes mthi/mtlo writes. It also raises the stall request that the hazard logic uses to freeze D-stage HI/LO-using instructions while an operation is in flight.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  E-stage instruction is an MD op (decoded from E-stage MDOp != NONE)
md_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (= NONE)
rs_val  input  32  forwarded E-stage rs operand
rt_val  input  32  forwarded E-stage rt operand
mf_sel  input  1  0 selects LO, 1 selects HI for mfhi/mflo read
d_md_use  input  1  D-stage instruction is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo
busy  output  1  multi-cycle operation in flight
stall_req  output  1  request to freeze D and flush E bubble
hi  output  32  HI register
lo  output  32  LO register
mf_out  output  32  mf_sel ? hi : lo, combinational

Behaviour:
- Reset (synchronous, edge with reset=1): hi=0, lo=0, counter=0, shadow regs=0, state IDLE, busy=0. Reset overrides start and an in-flight op. The pending result is discarded and HI/LO are not committed.
- States:
  - IDLE (counter==0).
  - RUN (counter!=0).
  - busy = (state==RUN).
- IDLE, start=1, md_op in {MULT,MULTU}:
  - At the edge, load counter=MULT_CYCLES.
  - Capture the 64-bit product into shadow {sh_hi, sh_lo}.
  - MULT is signed 32x32; MULTU is unsigned.
- IDLE, start=1, md_op in {DIV,DIVU}:
  - Load counter=DIV_CYCLES.
  - Capture sh_lo=quotient and sh_hi=remainder.
  - DIV is signed; quotient truncates toward zero; remainder takes the sign of the dividend. DIVU is unsigned.
- Divide by zero (rt_val==0):
  - Counter still runs DIV_CYCLES; busy behaves normally.
  - At commit, HI/LO stay unchanged (commit suppressed via a latched dz flag).
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- RUN: counter decrements each edge.
  - On the edge where counter==1: hi<=sh_hi, lo<=sh_lo (unless dz); counter becomes 0 and the state returns to IDLE.
- Latency, with start high in cycle t: busy=1 in cycles t+1..t+N. New HI/LO are visible from cycle t+N+1, and busy=0 in that same cycle.
- MTHI/MTLO with start=1 in IDLE: hi<=rs_val (resp. lo<=rs_val) at that edge, no busy.
- start=1 while RUN: the op is ignored entirely (no restart, no HI/LO write). The hazard unit guarantees this never occurs; assertion-check it in the bench.
- md_op NONE/7 with start=1: no effect.
- stall_req = d_md_use & (busy | (start & md_op in {MULT,MULTU,DIV,DIVU})). Purely combinational; no registered delay.
- mf_out reflects committed HI/LO only, never the shadow registers.
- Widths: products use 64-bit arithmetic with explicit sign extension for signed ops. The counter is 4 bits.

Test Plan:
- Reset mid-op: MULT 3*4, assert reset in cycle t+2 → next cycle busy=0, hi=lo=0, and no commit at t+6.
- MULT rs=0xFFFFFFFE (-2), rt=3 → busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x2, lo=0xFFFFFFFA.
- DIV rs=-7 (0xFFFFFFF9), rt=2 → busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=2 → lo=3, hi=1.
- DIV by zero with hi=0x11, lo=0x22 preloaded via MTHI/MTLO → busy for 10 cycles, then hi=0x11 and lo=0x22 unchanged. Also check MTHI rs=0x11 updates hi on the next edge with busy=0.
- Stall:
  - d_md_use=1 during start of MULT → stall_req=1 that cycle and for all 5 busy cycles, then 0 in cycle t+6.
  - d_md_use=0 → stall_req=0 throughout.
  - start=1 with MTLO → stall_req=0.
- mfhi/mflo read: during RUN of MULT 2*3 with lo=0x5 previously, mf_sel=0 → mf_out=0x5 until the commit edge, then 0x6.
